// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       beq_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_sel;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       halted;
  logic [3:0] state_out;

  modport master (
    input  opcode, beq_flag, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
           mem_to_reg, halted, state_out
  );

  modport slave (
    output opcode, beq_flag, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
           mem_to_reg, halted, state_out
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables, ALU op select and the shared memory handshake.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    HALT     = 4'd15
  } state_t;

  state_t state, next_state;
  logic   run;
  logic   r_legal, i_legal;

  // run is cleared asynchronously by reset and set on the first edge after
  // release, so outputs stay low until then and a reset mid-request drops
  // mem_req immediately without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
    end
  end

  always_comb begin
    r_legal = bus.opcode[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7};
    i_legal = bus.opcode[3:0] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h9, 4'hA};
  end

  always_comb begin
    next_state     = state;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_sel    = 4'b0000;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.halted     = 1'b0;
    bus.state_out  = state;

    case (state)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_sel   = 4'b0010;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next_state   = DECODE;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_sel   = 4'b0010;
        case (bus.opcode[5:4])
          2'b00:   next_state = r_legal ? EXEC_R : HALT;
          2'b01:   next_state = i_legal ? EXEC_I : HALT;
          2'b10:   next_state = (bus.opcode[3:1] == 3'b000) ? MEM_ADDR : HALT;
          default: begin
            if (bus.opcode[3:0] == 4'h0)      next_state = BRANCH;
            else if (bus.opcode[3:0] == 4'h1) next_state = JUMP;
            else                              next_state = HALT;
          end
        endcase
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_sel   = bus.opcode[3:0];
        next_state    = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_sel   = bus.opcode[3:0];
        next_state    = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = ~bus.opcode[4];
        next_state    = FETCH;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_sel   = 4'b0010;
        next_state    = bus.opcode[0] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) next_state = MEM_WB;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        next_state     = FETCH;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) next_state = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_sel   = 4'b0011;
        bus.pc_write  = bus.beq_flag;
        bus.pc_src    = 2'b01;
        next_state    = FETCH;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        next_state   = FETCH;
      end
      HALT: begin
        bus.halted = 1'b1;
      end
      default: next_state = HALT;
    endcase

    if (!run) begin
      next_state     = FETCH;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.iord       = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'b00;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_sel    = 4'b0000;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.halted     = 1'b0;
      bus.state_out  = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control: instruction sequences,
// memory waits, branch outcomes, illegal-opcode halt and reset behaviour.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 6'd0;
    bus.beq_flag = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
         bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.reg_write, bus.reg_dst,
         bus.mem_to_reg, bus.halted, bus.state_out} !== 22'd0) begin
      fails++; $display("FAIL reset_outputs_zero: some output nonzero, mem_req=%b ir_write=%b state=%0d exp all 0", bus.mem_req, bus.ir_write, bus.state_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_release_no_req: mem_req=%b exp 0 before first edge", bus.mem_req); end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL reset_first_edge_state: state=%0d exp 0", bus.state_out); end
    tests++;
    if ({bus.mem_req, bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 9'b1_0_0_01_0010) begin
      fails++; $display("FAIL fetch_controls: got %b exp 100010010", {bus.mem_req, bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
  endtask

  task automatic test_add();
    bus.opcode = 6'b000010;
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if ({bus.ir_write, bus.pc_write, bus.pc_src} !== 4'b1100) begin fails++; $display("FAIL add_fetch_load: got %b exp 1100", {bus.ir_write, bus.pc_write, bus.pc_src}); end
    tick();
    tests++;
    if (bus.state_out !== 4'd1) begin fails++; $display("FAIL add_decode_state: state=%0d exp 1", bus.state_out); end
    tests++;
    if ({bus.mem_req, bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 8'b0_0_11_0010) begin
      fails++; $display("FAIL add_decode_ctrl: got %b exp 00110010", {bus.mem_req, bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd2) begin fails++; $display("FAIL add_exec_state: state=%0d exp 2", bus.state_out); end
    tests++;
    if ({bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 7'b1_00_0010) begin
      fails++; $display("FAIL add_exec_ctrl: got %b exp 1000010", {bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd4) begin fails++; $display("FAIL add_wb_state: state=%0d exp 4", bus.state_out); end
    tests++;
    if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin fails++; $display("FAIL add_wb_ctrl: got %b exp 110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL add_back_to_fetch: state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_lw_wait();
    bus.opcode = 6'b100000;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.alu_src_a, bus.alu_src_b, bus.alu_sel} !== 11'b0101_1_10_0010) begin
      fails++; $display("FAIL lw_mem_addr: got %b exp 01011100010", {bus.state_out, bus.alu_src_a, bus.alu_src_b, bus.alu_sel});
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = (i == 2);
      #1;
      tests++;
      if ({bus.state_out, bus.mem_req, bus.iord, bus.mem_we, bus.ir_write} !== 8'b0110_1_1_0_0) begin
        fails++; $display("FAIL lw_mem_rd_cycle%0d: got %b exp 01101100", i, {bus.state_out, bus.mem_req, bus.iord, bus.mem_we, bus.ir_write});
      end
      tick();
    end
    tests++;
    if ({bus.state_out, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 7'b0111_1_0_1) begin
      fails++; $display("FAIL lw_mem_wb: got %b exp 0111101", {bus.state_out, bus.reg_write, bus.reg_dst, bus.mem_to_reg});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL lw_back_to_fetch: state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_sw_fetch_wait();
    bus.opcode = 6'b100001;
    bus.mem_ready = 1'b0;
    #1;
    tests++;
    if ({bus.mem_req, bus.ir_write, bus.pc_write} !== 3'b100) begin fails++; $display("FAIL sw_fetch_wait: got %b exp 100", {bus.mem_req, bus.ir_write, bus.pc_write}); end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL sw_fetch_hold: state=%0d exp 0", bus.state_out); end
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if (bus.ir_write !== 1'b1) begin fails++; $display("FAIL sw_fetch_ready: ir_write=%b exp 1", bus.ir_write); end
    tick();
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.mem_req, bus.mem_we, bus.iord} !== 7'b1000_111) begin
      fails++; $display("FAIL sw_mem_wr: got %b exp 1000111", {bus.state_out, bus.mem_req, bus.mem_we, bus.iord});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL sw_back_to_fetch: state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_beq();
    bus.opcode = 6'b110000;
    bus.mem_ready = 1'b1;
    bus.beq_flag = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.pc_write, bus.pc_src, bus.alu_sel, bus.alu_src_a, bus.alu_src_b} !== 14'b1001_1_01_0011_1_00) begin
      fails++; $display("FAIL beq_taken: got %b exp 10011010011100", {bus.state_out, bus.pc_write, bus.pc_src, bus.alu_sel, bus.alu_src_a, bus.alu_src_b});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL beq_back_to_fetch: state=%0d exp 0", bus.state_out); end
    bus.beq_flag = 1'b0;
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.pc_write, bus.alu_sel} !== 9'b1001_0_0011) begin
      fails++; $display("FAIL beq_not_taken: got %b exp 100100011", {bus.state_out, bus.pc_write, bus.alu_sel});
    end
    bus.beq_flag = 1'b1;
    #1;
    tests++;
    if (bus.pc_write !== 1'b1) begin fails++; $display("FAIL beq_flag_comb: pc_write=%b exp 1", bus.pc_write); end
    bus.beq_flag = 1'b0;
    tick();
  endtask

  task automatic test_jump();
    bus.opcode = 6'b110001;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.pc_write, bus.pc_src} !== 7'b1010_1_10) begin
      fails++; $display("FAIL jump_ctrl: got %b exp 1010110", {bus.state_out, bus.pc_write, bus.pc_src});
    end
    tick();
    tests++;
    if (bus.state_out !== 4'd0) begin fails++; $display("FAIL jump_back_to_fetch: state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_lui();
    bus.opcode = 6'b011010;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.state_out, bus.alu_sel, bus.alu_src_a, bus.alu_src_b} !== 11'b0011_1010_1_10) begin
      fails++; $display("FAIL lui_exec_i: got %b exp 00111010110", {bus.state_out, bus.alu_sel, bus.alu_src_a, bus.alu_src_b});
    end
    tick();
    tests++;
    if ({bus.state_out, bus.reg_write, bus.reg_dst} !== 6'b0100_1_0) begin
      fails++; $display("FAIL lui_wb: got %b exp 010010", {bus.state_out, bus.reg_write, bus.reg_dst});
    end
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bus.opcode = 6'b110001;
    bus.mem_ready = 1'b0;
    #1;
    tests++;
    if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL midrst_req_before: mem_req=%b exp 1", bus.mem_req); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.mem_req, bus.state_out} !== 5'b0_0000) begin fails++; $display("FAIL midrst_async_drop: got %b exp 00000", {bus.mem_req, bus.state_out}); end
    bus.mem_ready = 1'b1;
    #1;
    tests++;
    if (bus.ir_write !== 1'b0) begin fails++; $display("FAIL midrst_no_ir_write: ir_write=%b exp 0", bus.ir_write); end
    @(posedge clk);
    #1;
    tests++;
    if ({bus.mem_req, bus.ir_write, bus.state_out} !== 6'b0) begin fails++; $display("FAIL midrst_hold: got %b exp 000000", {bus.mem_req, bus.ir_write, bus.state_out}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.ir_write !== 1'b0) begin fails++; $display("FAIL midrst_release_no_ir: ir_write=%b exp 0", bus.ir_write); end
    tick();
    tests++;
    if ({bus.state_out, bus.mem_req, bus.ir_write} !== 6'b0000_1_1) begin
      fails++; $display("FAIL midrst_refetch: got %b exp 000011", {bus.state_out, bus.mem_req, bus.ir_write});
    end
    tick();
    tick();
    tests++;
    if (bus.state_out !== 4'd10) begin fails++; $display("FAIL midrst_jump: state=%0d exp 10", bus.state_out); end
    tick();
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b000110;
    bus.mem_ready = 1'b1;
    tick();
    tests++;
    if (bus.state_out !== 4'd1) begin fails++; $display("FAIL illegal_decode: state=%0d exp 1", bus.state_out); end
    tick();
    tests++;
    if ({bus.state_out, bus.halted} !== 5'b1111_1) begin fails++; $display("FAIL illegal_halt: got %b exp 11111", {bus.state_out, bus.halted}); end
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({bus.state_out, bus.halted, bus.mem_req, bus.pc_write, bus.reg_write} !== 8'b1111_1_000) begin
        fails++; $display("FAIL illegal_stay%0d: got %b exp 11111000", i, {bus.state_out, bus.halted, bus.mem_req, bus.pc_write, bus.reg_write});
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.halted, bus.state_out} !== 5'b0) begin fails++; $display("FAIL illegal_rst_clear: got %b exp 00000", {bus.halted, bus.state_out}); end
    #3;
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.state_out, bus.halted, bus.mem_req} !== 6'b0000_0_1) begin
      fails++; $display("FAIL illegal_restart: got %b exp 000001", {bus.state_out, bus.halted, bus.mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_fetch_wait();
    test_beq();
    test_jump();
    test_lui();
    test_reset_mid_fetch();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
